decode_stage: RTL and testbench

Instruction decode and issue stage of the RISC-V core. Accepts a fetched instruction, drives the register-file read addresses, decodes fields and immediate, and checks a register scoreboard for RAW/WAW hazards. Registers the result into the ID/EX pipeline register behind a valid/ready handshake. Sits between fetch and execute, directly in front of `register_file`, and shares the writeback port that writes it.

---
 rtl/rv_pkg.sv | 58 +++++
 rtl/decode_stage_imm_gen.sv | 30 +++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: widths, base opcodes, immediate formats,
// and the per-opcode control lookup used by the decode stage.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic     legal;
    logic     use_rs1;
    logic     use_rs2;
    logic     wr_rd;
    imm_fmt_e fmt;
  } dec_ctl_t;

  // Unknown opcodes come back with every use/write flag clear, so they
  // behave as a NOP unless the trap flag is consumed downstream.
  function automatic dec_ctl_t decode_ctl(input logic [6:0] opcode);
    dec_ctl_t c;
    c.legal   = 1'b1;
    c.use_rs1 = 1'b0;
    c.use_rs2 = 1'b0;
    c.wr_rd   = 1'b0;
    c.fmt     = FMT_NONE;
    case (opcode)
      OP_LUI, OP_AUIPC: begin c.wr_rd = 1'b1; c.fmt = FMT_U; end
      OP_JAL:           begin c.wr_rd = 1'b1; c.fmt = FMT_J; end
      OP_JALR, OP_LOAD, OP_IMM: begin
        c.use_rs1 = 1'b1; c.wr_rd = 1'b1; c.fmt = FMT_I;
      end
      OP_BRANCH: begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = FMT_B; end
      OP_STORE:  begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.fmt = FMT_S; end
      OP_OP: begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.wr_rd = 1'b1; end
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate extraction for the I/S/B/U/J formats,
// sign-extended to XLEN. FMT_NONE (R-type, unknown) yields 0.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Reassemble the scattered immediate bits for the selected format.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode/issue with register scoreboard,
// writeback bypass and a valid/ready ID/EX pipeline register.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flag unknown opcodes on
// ex_illegal; otherwise they issue as NOPs and ex_illegal is tied low).
module decode_stage
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  localparam int NREG = 1 << REG_AW;

  dec_ctl_t          ctl;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   op1, op2;
  logic [NREG-1:1]   busy, busy_nxt;
  logic [NREG-1:0]   busy_full;
  logic              wr_rd, byp1, byp2, wb_hits_rd;
  logic              haz1, haz2, haz_rd, hazard, fire;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign rd       = if_instr[11:7];
  assign ctl      = decode_ctl(if_instr[6:0]);

  imm_gen u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (ctl.fmt),
    .imm   (imm)
  );

  // x0 is a sink: writing it allocates nothing and reading it never waits.
  assign wr_rd     = ctl.legal & ctl.wr_rd & (rd != '0);
  assign busy_full = {busy, 1'b0};

  // A writeback landing this cycle both resolves the hazard and feeds the operand.
  assign byp1       = wb_valid & (wb_rd != '0) & (wb_rd == rs1_addr);
  assign byp2       = wb_valid & (wb_rd != '0) & (wb_rd == rs2_addr);
  assign wb_hits_rd = wb_valid & (wb_rd == rd);

  assign haz1   = ctl.use_rs1 & busy_full[rs1_addr] & ~byp1;
  assign haz2   = ctl.use_rs2 & busy_full[rs2_addr] & ~byp2;
  assign haz_rd = wr_rd & busy_full[rd] & ~wb_hits_rd;
  assign hazard = haz1 | haz2 | haz_rd;

  assign if_ready = reset & ~flush & ~hazard & (~ex_valid | ex_ready);
  assign fire     = if_valid & if_ready;

  assign op1 = ~ctl.use_rs1 ? '0 : (byp1 ? wb_data : rs1_data);
  assign op2 = ~ctl.use_rs2 ? '0 : (byp2 ? wb_data : rs2_data);

  // Scoreboard next state: clears first so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid && wb_rd != '0)
      busy_nxt[wb_rd] = 1'b0;
    if (flush && ex_valid && ex_reg_write)
      busy_nxt[ex_rd] = 1'b0;
    if (fire && wr_rd)
      busy_nxt[rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  // ID/EX register: valid follows the handshake, payload only moves on fire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7    <= '0;
      ex_reg_write <= 1'b0;
    end else begin
      if (flush)         ex_valid <= 1'b0;
      else if (fire)     ex_valid <= 1'b1;
      else if (ex_ready) ex_valid <= 1'b0;
      if (fire) begin
        ex_pc        <= if_pc;
        ex_op1       <= op1;
        ex_op2       <= op2;
        ex_imm       <= imm;
        ex_rd        <= rd;
        ex_opcode    <= if_instr[6:0];
        ex_funct3    <= if_instr[14:12];
        ex_funct7    <= if_instr[31:25];
        ex_reg_write <= wr_rd;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Illegal-opcode flag travels with the payload.
  always_ff @(posedge clk) begin
    if (!reset)    ex_illegal <= 1'b0;
    else if (fire) ex_illegal <= ~ctl.legal;
  end
`else
  assign ex_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed multi-cycle sequences,
// a decode vector table, and randomized traffic against a reference model.
module tb_decode_stage;
  import rv_pkg::*;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              if_valid, if_ready;
  logic [31:0]       if_instr;
  logic [XLEN-1:0]   if_pc;
  logic [REG_AW-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              ex_valid, ex_ready;
  logic [XLEN-1:0]   ex_pc, ex_op1, ex_op2, ex_imm;
  logic [REG_AW-1:0] ex_rd;
  logic [6:0]        ex_opcode, ex_funct7;
  logic [2:0]        ex_funct3;
  logic              ex_reg_write, ex_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_valid = 0; flush = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    ex_ready = 1; rs1_data = 0; rs2_data = 0;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    if_valid = 1; if_instr = ins; if_pc = pc; rs1_data = d1; rs2_data = d2;
  endtask

  // Reference decode: operand use, rd write and immediate value from the
  // instruction-format definitions, computed as signed integer sums.
  function automatic void mdec(input logic [31:0] ins, output bit legal, output bit u1,
                               output bit u2, output bit wr, output logic [31:0] imm);
    int v;
    legal = 1; u1 = 0; u2 = 0; wr = 0; v = 0;
    case (ins[6:0])
      OP_LUI, OP_AUIPC: begin wr = 1; v = int'(ins[31:12]) * 4096; end
      OP_JAL: begin
        wr = 1;
        v = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
            - (ins[31] ? (1 << 20) : 0);
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        u1 = 1; wr = 1;
        v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
      end
      OP_STORE: begin
        u1 = 1; u2 = 1;
        v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
      end
      OP_BRANCH: begin
        u1 = 1; u2 = 1;
        v = int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 + int'(ins[7]) * 2048
            - (ins[31] ? 4096 : 0);
      end
      OP_OP: begin u1 = 1; u2 = 1; wr = 1; end
      default: legal = 0;
    endcase
    imm = v;
  endfunction

  typedef struct {
    logic [31:0] instr, pc, d1, d2;
    logic [31:0] e_imm, e_op1, e_op2;
    logic [4:0]  e_rd;
    logic        e_wr, e_ill;
  } vec_t;

  vec_t vt [10];

  // Reference model state.
  bit [31:0]   mb;
  logic        mv, mwr, mill;
  logic [31:0] mpc, mop1, mop2, mimm;
  logic [4:0]  mrd;
  logic [6:0]  ops [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h00500093, 32'h100, 32'h0,  32'h55, 32'h5,        32'h0,  32'h0,  5'd1,  1, 0};
    vt[1] = '{32'h002081B3, 32'h104, 32'h11, 32'h22, 32'h0,        32'h11, 32'h22, 5'd3,  1, 0};
    vt[2] = '{32'hFE20AE23, 32'h108, 32'h33, 32'h44, 32'hFFFFFFFC, 32'h33, 32'h44, 5'd28, 0, 0};
    vt[3] = '{32'hFE208CE3, 32'h10C, 32'h66, 32'h77, 32'hFFFFFFF8, 32'h66, 32'h77, 5'd25, 0, 0};
    vt[4] = '{32'h123452B7, 32'h110, 32'h99, 32'h88, 32'h12345000, 32'h0,  32'h0,  5'd5,  1, 0};
    vt[5] = '{32'h001000EF, 32'h114, 32'h1,  32'h2,  32'h800,      32'h0,  32'h0,  5'd1,  1, 0};
    vt[6] = '{32'hFFF3A303, 32'h118, 32'hAA, 32'hBB, 32'hFFFFFFFF, 32'hAA, 32'h0,  5'd6,  1, 0};
    vt[7] = '{32'h00001017, 32'h11C, 32'h3,  32'h4,  32'h1000,     32'h0,  32'h0,  5'd0,  0, 0};
    vt[8] = '{32'h0000827F, 32'h120, 32'h5,  32'h6,  32'h0,        32'h0,  32'h0,  5'd4,  0, ILL};
    vt[9] = '{32'h00C18167, 32'h124, 32'hCC, 32'hDD, 32'hC,        32'hCC, 32'h0,  5'd2,  1, 0};
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
            OP_IMM, OP_OP, 7'b1111111};

    // Reset held low for two cycles.
    idle(); if_instr = 0; if_pc = 0; reset = 0;
    tick; tick;
    chk("rst_if_ready", if_ready, 0);
    chk("rst_ex_valid", ex_valid, 0);
    reset = 1; #1;
    chk("rel_if_ready", if_ready, 1);
    chk("rel_ex_payload", {ex_pc | ex_op1 | ex_op2 | ex_imm}, 0);
    chk("rel_ex_fields", {ex_rd, ex_opcode, ex_funct3, ex_funct7, ex_reg_write, ex_illegal}, 0);

    // addi x1,x0,5 issues with one cycle of latency.
    offer(32'h00500093, 32'h40, 0, 0);
    tick;
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", ex_rd, 1);
    chk("addi_rw", ex_reg_write, 1);
    chk("addi_pc", ex_pc, 32'h40);

    // add x3,x1,x2 waits for x1's writeback, then takes the bypassed value.
    offer(32'h002081B3, 32'h44, 0, 32'h22);
    #1 chk("raw_stall0", if_ready, 0);
    tick;
    chk("raw_stall1", if_ready, 0);
    tick;
    wb_valid = 1; wb_rd = 1; wb_data = 32'hABCD1234;
    #1 chk("raw_wb_ready", if_ready, 1);
    tick;
    wb_valid = 0;
    chk("raw_valid", ex_valid, 1);
    chk("raw_op1_bypass", ex_op1, 32'hABCD1234);
    chk("raw_op2", ex_op2, 32'h22);
    chk("raw_rd", ex_rd, 3);

    // Execute backpressure: payload frozen, no acceptance.
    ex_ready = 0;
    offer(32'h00900213, 32'h48, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_if_ready", if_ready, 0);
      chk("bp_valid", ex_valid, 1);
      chk("bp_op1", ex_op1, 32'hABCD1234);
      chk("bp_pc", ex_pc, 32'h44);
      tick;
    end
    ex_ready = 1;
    #1 chk("bp_release_ready", if_ready, 1);
    tick;
    chk("bp_next_imm", ex_imm, 9);
    chk("bp_next_rd", ex_rd, 4);

    // Flush kills ID/EX (rd=5) and the offered instruction.
    offer(32'h00100293, 32'h4C, 0, 0);
    tick;
    chk("fl_pre_rd", ex_rd, 5);
    flush = 1;
    offer(32'h00200313, 32'h50, 0, 0);
    #1 chk("fl_if_ready", if_ready, 0);
    tick;
    flush = 0;
    chk("fl_ex_valid", ex_valid, 0);
    offer(32'h006283B3, 32'h54, 32'h5555, 32'h6666);
    #1 chk("fl_busy_cleared", if_ready, 1);
    tick;
    chk("fl_after_valid", ex_valid, 1);
    chk("fl_after_rd", ex_rd, 7);
    chk("fl_after_op1", ex_op1, 32'h5555);
    chk("fl_after_op2", ex_op2, 32'h6666);

    // addi x0,x0,7: no register write, no later stall on x0.
    offer(32'h00700013, 32'h58, 0, 0);
    tick;
    chk("x0_rw", ex_reg_write, 0);
    chk("x0_imm", ex_imm, 7);
    offer(32'h00100413, 32'h5C, 0, 0);
    #1 chk("x0_no_stall", if_ready, 1);
    tick;
    chk("x0_next_rd", ex_rd, 8);

    // Unknown opcode.
    offer(32'h0000807F, 32'h60, 32'h1234, 32'h5678);
    tick;
    chk("ill_valid", ex_valid, 1);
    chk("ill_flag", ex_illegal, ILL);
    chk("ill_rw", ex_reg_write, 0);
    chk("ill_ops", ex_op1 | ex_op2, 0);
    idle(); tick;

    // Vector table from a clean scoreboard; each result is written back after issue.
    reset = 0; tick; tick; reset = 1;
    foreach (vt[k]) begin
      offer(vt[k].instr, vt[k].pc, vt[k].d1, vt[k].d2);
      #1 chk("tbl_ready", if_ready, 1);
      tick;
      if_valid = 0;
      chk("tbl_valid", ex_valid, 1);
      chk("tbl_pc", ex_pc, vt[k].pc);
      chk("tbl_imm", ex_imm, vt[k].e_imm);
      chk("tbl_op1", ex_op1, vt[k].e_op1);
      chk("tbl_op2", ex_op2, vt[k].e_op2);
      chk("tbl_rd", ex_rd, vt[k].e_rd);
      chk("tbl_rw", ex_reg_write, vt[k].e_wr);
      chk("tbl_ill", ex_illegal, vt[k].e_ill);
      wb_valid = vt[k].e_wr; wb_rd = vt[k].e_rd;
      tick;
      wb_valid = 0;
    end

    // Randomized traffic against the reference model.
    idle(); reset = 0; tick; tick; reset = 1;
    mb = 0; mv = 0; mwr = 0; mill = 0; mpc = 0; mop1 = 0; mop2 = 0; mimm = 0; mrd = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins, imm, nop1, nop2;
      bit legal, u1, u2, wr, byp1, byp2, haz, rdy, fire;
      bit [31:0] nb;
      logic [4:0] r1, r2, rd;

      chk("rnd_ex_valid", ex_valid, mv);
      chk("rnd_ex_pc", ex_pc, mpc);
      chk("rnd_ex_op1", ex_op1, mop1);
      chk("rnd_ex_op2", ex_op2, mop2);
      chk("rnd_ex_imm", ex_imm, mimm);
      chk("rnd_ex_ctl", {ex_rd, ex_reg_write, ex_illegal}, {mrd, mwr, mill});

      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      if_instr = ins; if_pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      if_valid = ($urandom_range(0, 9) < 8);
      ex_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      wb_valid = ($urandom_range(0, 9) < 3);
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;

      r1 = ins[19:15]; r2 = ins[24:20]; rd = ins[11:7];
      mdec(ins, legal, u1, u2, wr, imm);
      wr = wr && (rd != 0);
      byp1 = wb_valid && wb_rd != 0 && wb_rd == r1;
      byp2 = wb_valid && wb_rd != 0 && wb_rd == r2;
      haz = (u1 && mb[r1] && !byp1) || (u2 && mb[r2] && !byp2) ||
            (wr && mb[rd] && !(wb_valid && wb_rd == rd));
      rdy = !flush && !haz && (!mv || ex_ready);
      fire = if_valid && rdy;
      chk("rnd_if_ready", if_ready, rdy);
      chk("rnd_rs_addr", {rs1_addr, rs2_addr}, {r1, r2});

      nb = mb;
      if (wb_valid && wb_rd != 0) nb[wb_rd] = 0;
      if (flush && mv && mwr) nb[mrd] = 0;
      if (fire && wr) nb[rd] = 1;
      nop1 = !u1 ? 0 : (byp1 ? wb_data : rs1_data);
      nop2 = !u2 ? 0 : (byp2 ? wb_data : rs2_data);

      tick;
      mb = nb;
      if (flush) mv = 0;
      else if (fire) mv = 1;
      else if (ex_ready) mv = 0;
      if (fire) begin
        mpc = if_pc; mop1 = nop1; mop2 = nop2; mimm = imm; mrd = rd;
        mwr = wr; mill = legal ? 1'b0 : ILL;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
